// File: rtl/muldiv_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
// Op codes, FSM states and multiplier latency bounds.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  localparam int MUL_LAT_MIN = 1;
  localparam int MUL_LAT_MAX = 4;

  function automatic logic op_signed(input logic [1:0] op);
    return !op[0];
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring radix-2 divider step datapath on unsigned magnitudes.
// Exposes next-step quotient/remainder so the caller can latch the final step.
module muldiv_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             last_o,
  output logic [WIDTH-1:0] quo_d_o,
  output logic [WIDTH-1:0] rem_d_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   diff;
  logic             ge;

  assign r_sh    = {rem_q, quo_q[WIDTH-1]};
  assign diff    = r_sh - {1'b0, dvs_q};
  assign ge      = !diff[WIDTH];
  assign rem_d_o = ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
  assign quo_d_o = {quo_q[WIDTH-2:0], ge};
  assign last_o  = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
      cnt_q <= '0;
    end else if (step_i) begin
      rem_q <= rem_d_o;
      quo_q <= quo_d_o;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit feeding the HI/LO write path.
// Owns the FSM, operand capture, multiplier, sign fixup and result regs.
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             flushE,
  output logic             stall_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int LAT =
    (MUL_LATENCY < MUL_LAT_MIN) ? MUL_LAT_MIN :
    (MUL_LATENCY > MUL_LAT_MAX) ? MUL_LAT_MAX : MUL_LATENCY;
  localparam logic [2:0] LAT_LAST = 3'(LAT - 1);

  state_e           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             negq_q;
  logic             negr_q;
  logic             bzero_q;
  logic [2:0]       cnt_q;
  logic             valid_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             idle_or_done;
  logic             accept;
  logic             sgn_in;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept  = idle_or_done && startE && !flushE;
  assign stall_o = accept || (state_q == S_MUL) || (state_q == S_DIV);
  assign valid_o = valid_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

  assign sgn_in = op_signed(opE);
  assign a_neg  = sgn_in && srcaE[WIDTH-1];
  assign b_neg  = sgn_in && srcbE[WIDTH-1];
  assign a_mag  = a_neg ? -srcaE : srcaE;
  assign b_mag  = b_neg ? -srcbE : srcbE;

  logic             div_last;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] rem_d;

  muldiv_div_core #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .load_i    (accept && opE[1]),
    .step_i    ((state_q == S_DIV) && !bzero_q),
    .dividend_i(a_mag),
    .divisor_i (b_mag),
    .last_o    (div_last),
    .quo_d_o   (quo_d),
    .rem_d_o   (rem_d)
  );

  logic             sgn_q;
  logic [2*WIDTH-1:0] ax;
  logic [2*WIDTH-1:0] bx;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign sgn_q   = op_signed(op_q);
  assign ax      = {{WIDTH{sgn_q && a_q[WIDTH-1]}}, a_q};
  assign bx      = {{WIDTH{sgn_q && b_q[WIDTH-1]}}, b_q};
  assign prod    = ax * bx;
  assign quo_fix = negq_q ? -quo_d : quo_d;
  assign rem_fix = negr_q ? -rem_d : rem_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      bzero_q <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      if (flushE) begin
        state_q <= S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE, S_DONE: begin
            if (startE) begin
              op_q    <= opE;
              a_q     <= srcaE;
              b_q     <= srcbE;
              negq_q  <= a_neg ^ b_neg;
              negr_q  <= a_neg;
              bzero_q <= (srcbE == '0);
              cnt_q   <= '0;
              state_q <= opE[1] ? S_DIV : S_MUL;
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_MUL: begin
            if (cnt_q == LAT_LAST) begin
              state_q <= S_DONE;
              valid_q <= 1'b1;
              hi_q    <= prod[2*WIDTH-1:WIDTH];
              lo_q    <= prod[WIDTH-1:0];
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_DIV: begin
            // Zero divisor bypasses the iterations entirely.
            if (bzero_q) begin
              state_q <= S_DONE;
              valid_q <= 1'b1;
              hi_q    <= a_q;
              lo_q    <= '1;
            end else if (div_last) begin
              state_q <= S_DONE;
              valid_q <= 1'b1;
              hi_q    <= rem_fix;
              lo_q    <= quo_fix;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
